// File: rtl/lfsr_crc16.sv
// Sequential CRC-16 generator: folds BPC message bits per clock through a 16-bit LFSR,
// then holds the CRC and a registered copy of the frame until the next accepted start.
module lfsr_crc16 #(
  parameter int unsigned MSG_W  = 112,
  parameter int unsigned BPC    = 8,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MSG_W+15:0] data_in,
  output logic             busy,
  output logic             rdy,
  output logic [MSG_W+15:0] data_out,
  output logic [15:0]      lfsr_out
);

  localparam int unsigned N  = MSG_W / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [MSG_W-1:0] msg;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [CW-1:0]    cnt;
  logic             fb;
  logic             unused_pad;

  // The zero pad below the message never enters the LFSR.
  assign unused_pad = ^data_in[15:0];

  // One chunk of BPC bits, MSB of the message register first.
  always_comb begin
    lfsr_next = lfsr;
    fb        = 1'b0;
    for (int unsigned i = 0; i < BPC; i++) begin
      fb        = lfsr_next[15] ^ msg[MSG_W-1-i];
      lfsr_next = {lfsr_next[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      lfsr_out <= '0;
      data_out <= '0;
      cnt      <= '0;
      lfsr     <= '0;
      msg      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SHIFT;
            data_out <= data_in;
            msg      <= data_in[MSG_W+15:16];
            lfsr     <= INIT;
            cnt      <= '0;
            busy     <= 1'b1;
            rdy      <= 1'b0;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_next;
          msg  <= msg << BPC;
          if (cnt == CW'(N - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            rdy      <= 1'b1;
            lfsr_out <= lfsr_next ^ XOROUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_crc16.sv
// Bench for lfsr_crc16: four parameterisations sharing clk/rst, table-driven known
// vectors plus directed multi-cycle sequences.
module tb_lfsr_crc16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: defaults, b: MSG_W=72, c: INIT=0, d: BPC=1
  logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [127:0] din_a = '0, din_c = '0, din_d = '0;
  logic [87:0]  din_b = '0;
  logic         busy_a, busy_b, busy_c, busy_d;
  logic         rdy_a, rdy_b, rdy_c, rdy_d;
  logic [127:0] dout_a, dout_c, dout_d;
  logic [87:0]  dout_b;
  logic [15:0]  crc_a, crc_b, crc_c, crc_d;

  lfsr_crc16 u_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(din_a),
    .busy(busy_a), .rdy(rdy_a), .data_out(dout_a), .lfsr_out(crc_a)
  );
  lfsr_crc16 #(.MSG_W(72)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(din_b),
    .busy(busy_b), .rdy(rdy_b), .data_out(dout_b), .lfsr_out(crc_b)
  );
  lfsr_crc16 #(.INIT(16'h0000)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(din_c),
    .busy(busy_c), .rdy(rdy_c), .data_out(dout_c), .lfsr_out(crc_c)
  );
  lfsr_crc16 #(.BPC(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .data_in(din_d),
    .busy(busy_d), .rdy(rdy_d), .data_out(dout_d), .lfsr_out(crc_d)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int           dut;
    logic [127:0] data;
    logic [15:0]  exp_crc;
    int           exp_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Bit-serial reference: CCITT polynomial, XOROUT=0.
  function automatic logic [15:0] crc_model(input logic [127:0] f, input int msg_w,
                                            input logic [15:0] init);
    logic [15:0] l;
    logic        b;
    l = init;
    for (int i = msg_w + 15; i >= 16; i--) begin
      b = l[15] ^ f[i];
      l = {l[14:0], 1'b0} ^ (b ? 16'h1021 : 16'h0000);
    end
    return l;
  endfunction

  task automatic drive(input int d, input logic s, input logic [127:0] data);
    case (d)
      0: begin start_a = s; din_a = data; end
      1: begin start_b = s; din_b = data[87:0]; end
      2: begin start_c = s; din_c = data; end
      default: begin start_d = s; din_d = data; end
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0: return rdy_a;
      1: return rdy_b;
      2: return rdy_c;
      default: return rdy_d;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  function automatic logic [15:0] get_crc(input int d);
    case (d)
      0: return crc_a;
      1: return crc_b;
      2: return crc_c;
      default: return crc_d;
    endcase
  endfunction

  function automatic logic [127:0] get_dout(input int d);
    case (d)
      0: return dout_a;
      1: return {40'h0, dout_b};
      2: return dout_c;
      default: return dout_d;
    endcase
  endfunction

  // Counts edges after the accepting edge until rdy rises (bounded).
  task automatic wait_rdy(input int d, inout int lat);
    while (!get_rdy(d) && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_frame(input int d, input logic [127:0] data, output int lat);
    drive(d, 1'b1, data);
    tick();
    drive(d, 1'b0, data);
    lat = 0;
    wait_rdy(d, lat);
  endtask

  function automatic logic [127:0] rnd_frame();
    logic [127:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[15:0] = 16'h0;
    return f;
  endfunction

  initial begin
    logic [127:0] f0, f1;
    logic [15:0]  held;
    int           lat;

    tbl[0] = '{1, {40'h0, "123456789", 16'h0}, 16'h29B1, 9};
    tbl[1] = '{2, {111'b0, 1'b1, 16'h0}, 16'h1021, 14};
    tbl[2] = '{2, 128'h0, 16'h0000, 14};
    tbl[3] = '{2, {110'b0, 2'b10, 16'h0}, 16'h2042, 14};
    tbl[4] = '{2, {108'b0, 4'b1000, 16'h0}, 16'h8108, 14};
    tbl[5] = '{2, {107'b0, 5'b10000, 16'h0}, 16'h1231, 14};
    tbl[6] = '{2, {40'h0, "123456789", 16'h0}, 16'h31C3, 14};

    // Reset with start held high on every instance.
    for (int d = 0; d < 4; d++) drive(d, 1'b1, {8{16'hA5C3}});
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {127'b0, busy_a}, 128'h0);
    check("rst_rdy", {127'b0, rdy_a}, 128'h0);
    check("rst_crc", {112'b0, crc_a}, 128'h0);
    check("rst_dout", dout_a, 128'h0);
    check("rst_dout_d", dout_d, 128'h0);
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 128'h0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_busy", {126'b0, busy_a, rdy_a}, 128'h0);

    // Known vectors.
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].dut, tbl[i].data, lat);
      check($sformatf("vec%0d_lat", i), 128'(lat), 128'(tbl[i].exp_lat));
      check($sformatf("vec%0d_crc", i), {112'b0, get_crc(tbl[i].dut)}, {112'b0, tbl[i].exp_crc});
      check($sformatf("vec%0d_dout", i), get_dout(tbl[i].dut),
            (tbl[i].dut == 1) ? {40'h0, tbl[i].data[87:0]} : tbl[i].data);
    end

    // start pulsed throughout SHIFT is ignored.
    f0 = rnd_frame();
    drive(0, 1'b1, f0);
    tick();
    lat = 0;
    for (int i = 0; i < 13; i++) begin
      drive(0, 1'b1, rnd_frame());
      if (rdy_a) break;
      check("shift_busy", {127'b0, busy_a}, 128'h1);
      tick();
      lat++;
    end
    drive(0, 1'b0, 128'h0);
    wait_rdy(0, lat);
    check("ign_lat", 128'(lat), 128'd14);
    check("ign_crc", {112'b0, crc_a}, {112'b0, crc_model(f0, 112, 16'hFFFF)});
    check("ign_dout", dout_a, f0);
    check("done_busy", {127'b0, busy_a}, 128'h0);

    // DONE holds outputs.
    held = crc_a;
    tick();
    tick();
    tick();
    check("hold_rdy", {127'b0, rdy_a}, 128'h1);
    check("hold_crc", {112'b0, crc_a}, {112'b0, held});

    // Reset aborts SHIFT at cycle 7, then a clean frame.
    drive(0, 1'b1, rnd_frame());
    tick();
    drive(0, 1'b0, 128'h0);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {126'b0, busy_a, rdy_a}, 128'h0);
    check("abort_crc", {112'b0, crc_a}, 128'h0);
    check("abort_dout", dout_a, 128'h0);
    f0 = rnd_frame();
    run_frame(0, f0, lat);
    check("post_rst_lat", 128'(lat), 128'd14);
    check("post_rst_crc", {112'b0, crc_a}, {112'b0, crc_model(f0, 112, 16'hFFFF)});

    // Restart from DONE, for BPC=8 and the bit-serial instance.
    for (int d = 0; d < 4; d += 3) begin
      int n;
      n  = (d == 0) ? 14 : 112;
      f0 = rnd_frame();
      run_frame(d, f0, lat);
      check($sformatf("d%0d_first_lat", d), 128'(lat), 128'(n));
      check($sformatf("d%0d_first_crc", d), {112'b0, get_crc(d)}, {112'b0, crc_model(f0, 112, 16'hFFFF)});
      f1 = rnd_frame();
      drive(d, 1'b1, f1);
      tick();
      drive(d, 1'b0, 128'h0);
      check($sformatf("d%0d_rst_rdy", d), {126'b0, get_busy(d), get_rdy(d)}, 128'h2);
      check($sformatf("d%0d_new_dout", d), get_dout(d), f1);
      lat = 1;
      tick();
      wait_rdy(d, lat);
      check($sformatf("d%0d_b2b_lat", d), 128'(lat), 128'(n));
      check($sformatf("d%0d_b2b_crc", d), {112'b0, get_crc(d)}, {112'b0, crc_model(f1, 112, 16'hFFFF)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
